fifo_flagged: RTL and testbench

//  Parametrised synchronous FIFO. Next generation of the basic enq/deq FIFO.

---
 rtl/fifo_flagged.sv | 111 +++++++++++
 tb/tb_fifo_flagged.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// Purpose: single-clock FIFO with occupancy count, almost-full/almost-empty flags and overflow/underflow pulses.
// Latency: FWFT=0 gives read data 1 cycle after deq. FWFT=1 shows data 1 cycle after a write into an empty FIFO.
// Backpressure: enq on full is dropped unless a read is accepted in the same cycle; deq on empty is dropped. Each drop pulses an error flag.
//
// Ports:
//   clk, reset            clock (rising edge); synchronous active-low reset
//   enq, data_in          write request and write data
//   deq, data_out         read request and read data (timing set by FWFT)
//   empty, full           count == 0 / count == FIFO_DEPTH (registered)
//   almost_empty/_full    count <= AEMPTY_THRESH / count >= AFULL_THRESH (registered)
//   count                 occupancy 0..FIFO_DEPTH
//   overflow, underflow   1-cycle pulses for a dropped enq / deq
module fifo_flagged #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 4,
    parameter int FIFO_DEPTH    = 1 << ADDR_WIDTH,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq,
    input  logic                  deq,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    // Parameter sanity is enforced at elaboration. A bad configuration
    // should never reach silicon.
    if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("fifo_flagged: FIFO_DEPTH must equal 1<<ADDR_WIDTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH >= AFULL_THRESH) ||
        (AFULL_THRESH > FIFO_DEPTH)) begin : g_thresh_chk
        $error("fifo_flagged: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= FIFO_DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  deq_ok;
    logic                  enq_ok;
    logic [CNT_W-1:0]      count_nxt;

    // Accept decisions use pre-edge state. A full FIFO still takes a write
    // when a read frees a slot in the same cycle.
    always_comb begin
        deq_ok    = deq & ~empty;
        enq_ok    = enq & (~full | deq_ok);
        count_nxt = count + CNT_W'(enq_ok) - CNT_W'(deq_ok);
    end

    // Flags are registered from the next count. They line up with count in
    // the cycle after the causing edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AFULL_THRESH == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
            if (deq_ok) rd_ptr <= rd_ptr + 1'b1;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            almost_full  <= (count_nxt >= AFULL_C);
            overflow     <= enq & ~enq_ok;
            underflow    <= deq & ~deq_ok;
        end
    end

    // Storage is not reset. Writes are blocked while reset is asserted, so
    // reset wins over a coincident enq.
    always_ff @(posedge clk) begin
        if (reset && enq_ok) mem[wr_ptr] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        // The head word is shown combinationally from registered state.
        // Output is zero while the FIFO is empty.
        assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] data_q;
        always_ff @(posedge clk) begin
            if (!reset)      data_q <= '0;
            else if (deq_ok) data_q <= mem[rd_ptr];
        end
        assign data_out = data_q;
    end

endmodule

// File: tb/tb_fifo_flagged.sv
module tb_fifo_flagged;
    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq = 1'b0, deq = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [AW:0]   count;

    logic          f_enq = 1'b0, f_deq = 1'b0;
    logic [DW-1:0] f_din = '0;
    logic [DW-1:0] f_data_out;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [AW:0]   f_count;

    always #5 clk = ~clk;

    fifo_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .enq(enq), .deq(deq), .data_in(data_in),
        .data_out(data_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    fifo_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .enq(f_enq), .deq(f_deq), .data_in(f_din),
        .data_out(f_data_out), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    int passed = 0;
    int total  = 0;

    // Scoreboard and reference model for the registered-read instance
    logic [DW-1:0] sb[$];
    logic [DW-1:0] f_sb[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0, m_unf = 1'b0, m_deq_ok = 1'b0;
    logic [DW-1:0] m_dout = '0;

    // Drives one cycle and updates the model. Results are checked by the caller.
    task automatic drive(input logic e, input logic d, input logic [DW-1:0] x);
        logic enq_ok;
        m_deq_ok = d && (m_cnt > 0);
        enq_ok   = e && ((m_cnt < DEPTH) || m_deq_ok);
        m_ovf    = e && !enq_ok;
        m_unf    = d && !m_deq_ok;
        if (m_deq_ok) m_dout = sb.pop_front();
        if (enq_ok) sb.push_back(x);
        m_cnt = m_cnt + int'(enq_ok) - int'(m_deq_ok);
        enq = e; deq = d; data_in = x;
        @(posedge clk); #1;
        enq = 1'b0; deq = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000)
            $display("FAIL reset_flags: got %b want 101000",
                     {empty, full, almost_empty, almost_full, overflow, underflow});
        else passed++;
        total++;
        if (count !== 5'd0 || data_out !== 64'd0)
            $display("FAIL reset_count_data: count %0d data %h want 0/0", count, data_out);
        else passed++;
        total++;
        if (f_empty !== 1'b1 || f_data_out !== 64'd0)
            $display("FAIL reset_fwft: empty %b data %h want 1/0", f_empty, f_data_out);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 64'(i));
            total++;
            if ({count, empty, full, almost_empty, almost_full, overflow} !==
                {5'(i + 1), 1'b0, (i == 15), (i + 1 <= 2), (i + 1 >= 14), 1'b0})
                $display("FAIL fill[%0d]: cnt/e/f/ae/af/ovf got %0d/%b want %0d/%b", i, count,
                         {empty, full, almost_empty, almost_full, overflow}, i + 1,
                         {1'b0, (i == 15), (i + 1 <= 2), (i + 1 >= 14), 1'b0});
            else passed++;
        end
        drive(1'b1, 1'b0, 64'd99);
        total++;
        if (overflow !== 1'b1 || count !== 5'd16 || m_ovf !== 1'b1)
            $display("FAIL fill_overflow: ovf %b count %0d want 1/16", overflow, count);
        else passed++;
        drive(1'b0, 1'b0, 64'd0);
        total++;
        if (overflow !== 1'b0 || count !== 5'd16)
            $display("FAIL overflow_pulse: ovf %b count %0d want 0/16", overflow, count);
        else passed++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 64'd0);
            total++;
            if (data_out !== m_dout || data_out !== 64'(i) || count !== 5'(15 - i))
                $display("FAIL drain[%0d]: data %h count %0d want %h/%0d",
                         i, data_out, count, m_dout, 15 - i);
            else passed++;
        end
        total++;
        if (empty !== 1'b1 || almost_empty !== 1'b1)
            $display("FAIL drain_empty: empty %b ae %b want 1/1", empty, almost_empty);
        else passed++;
        drive(1'b0, 1'b1, 64'd0);
        total++;
        if (underflow !== 1'b1 || data_out !== 64'd15 || count !== 5'd0)
            $display("FAIL underflow: unf %b data %h count %0d want 1/f/0",
                     underflow, data_out, count);
        else passed++;
        drive(1'b0, 1'b0, 64'd0);
        total++;
        if (underflow !== 1'b0 || data_out !== 64'd15)
            $display("FAIL underflow_pulse: unf %b data %h want 0/f", underflow, data_out);
        else passed++;
    endtask

    task automatic test_full_enq_deq();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 64'(100 + i));
        drive(1'b1, 1'b1, 64'hAA);
        total++;
        if (overflow !== 1'b0 || count !== 5'd16 || full !== 1'b1 || data_out !== m_dout)
            $display("FAIL full_enq_deq: ovf %b count %0d full %b data %h want 0/16/1/%h",
                     overflow, count, full, data_out, m_dout);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 64'd0);
            total++;
            if (data_out !== m_dout)
                $display("FAIL full_drain[%0d]: got %h want %h", i, data_out, m_dout);
            else passed++;
        end
        total++;
        if (data_out !== 64'hAA || empty !== 1'b1)
            $display("FAIL full_last: data %h empty %b want aa/1", data_out, empty);
        else passed++;
    endtask

    task automatic test_wrap();
        int   sent = 0, recv = 0, cyc = 0, max_cnt = 0, errs = 0;
        logic e, d;
        while (recv < 40 && cyc < 1000) begin
            e = (sent < 40) && (m_cnt < 5) && ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) != 0);
            drive(e, d, 64'h1000 + 64'(sent));
            if (e) sent++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (count !== 5'(m_cnt) || underflow !== m_unf) errs++;
            if (m_deq_ok) begin
                total++;
                if (data_out !== 64'h1000 + 64'(recv))
                    $display("FAIL wrap_data[%0d]: got %h want %h",
                             recv, data_out, 64'h1000 + 64'(recv));
                else passed++;
                recv++;
            end
            cyc++;
        end
        total++;
        if (recv != 40) $display("FAIL wrap_budget: received %0d want 40", recv);
        else passed++;
        total++;
        if (max_cnt > 5 || errs != 0)
            $display("FAIL wrap_count: max %0d errs %0d want <=5/0", max_cnt, errs);
        else passed++;
    endtask

    task automatic test_fwft();
        f_enq = 1'b1; f_din = 64'h1234;
        @(posedge clk); #1;
        f_enq = 1'b0;
        total++;
        if (f_empty !== 1'b0 || f_data_out !== 64'h1234 || f_count !== 5'd1)
            $display("FAIL fwft_show: empty %b data %h count %0d want 0/1234/1",
                     f_empty, f_data_out, f_count);
        else passed++;
        total++;
        if ({f_full, f_ae, f_af, f_ovf, f_unf} !== 5'b01000)
            $display("FAIL fwft_flags: got %b want 01000", {f_full, f_ae, f_af, f_ovf, f_unf});
        else passed++;
        @(posedge clk); #1;
        total++;
        if (f_data_out !== 64'h1234)
            $display("FAIL fwft_hold: got %h want 1234", f_data_out);
        else passed++;
        f_deq = 1'b1;
        @(posedge clk); #1;
        f_deq = 1'b0;
        total++;
        if (f_empty !== 1'b1 || f_data_out !== 64'd0)
            $display("FAIL fwft_consume: empty %b data %h want 1/0", f_empty, f_data_out);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            f_enq = 1'b1; f_din = 64'hBEEF0 + 64'(i); f_sb.push_back(f_din);
            @(posedge clk); #1;
        end
        f_enq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (f_data_out !== f_sb[0])
                $display("FAIL fwft_seq[%0d]: got %h want %h", i, f_data_out, f_sb[0]);
            else passed++;
            void'(f_sb.pop_front());
            f_deq = 1'b1;
            @(posedge clk); #1;
        end
        f_deq = 1'b1;
        @(posedge clk); #1;
        f_deq = 1'b0;
        total++;
        if (f_empty !== 1'b1 || f_unf !== 1'b1)
            $display("FAIL fwft_underflow: empty %b unf %b want 1/1", f_empty, f_unf);
        else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 64'h500 + 64'(i));
        total++;
        if (count !== 5'd9) $display("FAIL pre_reset_count: got %0d want 9", count);
        else passed++;
        reset = 1'b0; enq = 1'b1; data_in = 64'hDEAD;
        @(posedge clk); #1;
        reset = 1'b1; enq = 1'b0;
        sb.delete(); m_cnt = 0; m_dout = '0;
        total++;
        if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000 ||
            count !== 5'd0 || data_out !== 64'd0)
            $display("FAIL mid_reset: flags %b count %0d data %h want 101000/0/0",
                     {empty, full, almost_empty, almost_full, overflow, underflow},
                     count, data_out);
        else passed++;
        drive(1'b0, 1'b0, 64'd0);
        total++;
        if (count !== 5'd0 || empty !== 1'b1)
            $display("FAIL reset_enq_ignored: count %0d empty %b want 0/1", count, empty);
        else passed++;
        drive(1'b1, 1'b0, 64'h77);
        drive(1'b0, 1'b1, 64'd0);
        total++;
        if (data_out !== 64'h77 || data_out !== m_dout)
            $display("FAIL post_reset_data: got %h want 77", data_out);
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_enq_deq();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
